// File: rtl/mmio_timer_responder_if.sv
// CPU-side bus bundle for the MMIO timer responder.
// One request in flight; Ack closes it with RdData/Err.
interface mmio_timer_responder_if;
   logic        Req;
   logic        We;
   logic [1:0]  Size;
   logic [31:0] Ad;
   logic [31:0] WrData;
   logic [31:0] RdData;
   logic        Ack;
   logic        Err;
   logic        Irq;

   modport master (
      output Req, We, Size, Ad, WrData,
      input  RdData, Ack, Err, Irq
   );

   modport slave (
      input  Req, We, Size, Ad, WrData,
      output RdData, Ack, Err, Irq
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT
// registers behind a fixed-latency request/ack bus.
module mmio_timer_responder #(
   parameter logic [31:0] BASE = 32'h0000_7F00,
   parameter int unsigned WAIT = 1
) (
   input logic Clk,
   input logic Reset,
   mmio_timer_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [2:0] WLOAD =
      (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

   state_t      state, state_nx;
   logic [2:0]  wcnt, wcnt_nx;

   logic        c_we;
   logic [1:0]  c_size;
   logic [31:0] c_ad;
   logic [31:0] c_wd;

   logic        en, mode, irq_en, pending;
   logic [31:0] preset, count;

   logic [31:0] off;
   logic        in_win, is_half, is_byte, is_word;
   logic        misal, bad;
   logic        resp, ok, wr, rd;
   logic [3:0]  bm;
   logic [31:0] m;
   logic [31:0] ctrl_rd, reg_rd, lane_rd, merged;
   logic        wr_ctrl, wr_pre, w1c, expire;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
         wcnt  <= 3'd0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      unique case (state)
         S_IDLE: begin
            if (bus.Req) begin
               if (WAIT == 0) begin
                  state_nx = S_RESP;
               end else begin
                  state_nx = S_WAIT;
                  wcnt_nx  = WLOAD;
               end
            end
         end
         S_WAIT: begin
            if (wcnt == 3'd0) state_nx = S_RESP;
            else              wcnt_nx  = wcnt - 3'd1;
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         c_we   <= 1'b0;
         c_size <= 2'b00;
         c_ad   <= 32'd0;
         c_wd   <= 32'd0;
      end else if (state == S_IDLE && bus.Req) begin
         c_we   <= bus.We;
         c_size <= bus.Size;
         c_ad   <= bus.Ad;
         c_wd   <= bus.WrData;
      end
   end

   // Window offset; BASE is 16-byte aligned so off[1:0] is the lane.
   always_comb begin
      off     = c_ad - BASE;
      in_win  = (off[31:4] == 28'd0);
      is_half = (c_size == 2'b01);
      is_byte = (c_size == 2'b10);
      is_word = !is_half && !is_byte;
      misal   = (is_half && off[0]) ||
                (is_word && off[1:0] != 2'b00);
      bad     = !in_win || misal;
      resp    = (state == S_RESP);
      ok      = resp && !bad;
      wr      = ok && c_we;
      rd      = ok && !c_we;
   end

   always_comb begin
      bm = 4'b1111;
      if (is_byte)      bm = 4'b0001 << off[1:0];
      else if (is_half) bm = off[1] ? 4'b1100 : 4'b0011;
      m = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
   end

   always_comb begin
      ctrl_rd = {pending, 28'd0, irq_en, mode, en};
      reg_rd  = 32'd0;
      unique case (off[3:2])
         2'd0:    reg_rd = ctrl_rd;
         2'd1:    reg_rd = preset;
         2'd2:    reg_rd = count;
         default: reg_rd = 32'd0;
      endcase
      lane_rd = reg_rd;
      if (is_byte)
         lane_rd = (reg_rd >> {off[1:0], 3'b000}) & 32'h0000_00FF;
      else if (is_half)
         lane_rd = (reg_rd >> {off[1], 4'b0000}) & 32'h0000_FFFF;
      merged  = (reg_rd & ~m) | (c_wd & m);
      wr_ctrl = wr && (off[3:2] == 2'd0);
      wr_pre  = wr && (off[3:2] == 2'd1);
      w1c     = wr_ctrl && c_wd[31] && bm[3];
      expire  = en && (count == 32'd1);
   end

   // Expiry outranks a same-cycle clear; PRESET write outranks reload.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         en      <= 1'b0;
         mode    <= 1'b0;
         irq_en  <= 1'b0;
         pending <= 1'b0;
         preset  <= 32'd0;
         count   <= 32'd0;
      end else begin
         if (wr_ctrl) begin
            en     <= merged[0];
            mode   <= merged[1];
            irq_en <= merged[2];
         end else if (expire && !mode) begin
            en <= 1'b0;
         end
         pending <= expire || (pending && !w1c);
         if (wr_pre) preset <= merged;
         if (wr_pre) begin
            count <= merged;
         end else if (en && count != 32'd0) begin
            if (expire && mode) count <= preset;
            else                count <= count - 32'd1;
         end
      end
   end

   assign bus.Ack    = resp;
   assign bus.Err    = resp && bad;
   assign bus.RdData = rd ? lane_rd : 32'd0;
   assign bus.Irq    = irq_en && pending;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for the MMIO timer: register table plus
// hand-timed sequences for expiry, reload, W1C race and reset abort.
module tb_mmio_timer_responder;

   localparam logic [31:0] B = 32'h0000_7F00;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad = 0;

   mmio_timer_responder_if bus ();

   mmio_timer_responder #(
      .BASE(B),
      .WAIT(1)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       nm;
      logic        we;
      logic [1:0]  size;
      logic [31:0] ad;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t v[21];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [1:0] size,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
      bit got;
      int lat;
      got = 0;
      lat = 0;
      rd  = 32'hx;
      err = 1'bx;
      @(negedge Clk);
      bus.Req    = 1'b1;
      bus.We     = we;
      bus.Size   = size;
      bus.Ad     = ad;
      bus.WrData = wd;
      @(posedge Clk);
      #1 bus.Req = 1'b0;
      for (int i = 1; i <= 16 && !got; i++) begin
         @(negedge Clk);
         if (bus.Ack) begin
            got = 1;
            lat = i;
            rd  = bus.RdData;
            err = bus.Err;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL ack_timeout: got none want ack at %h", ad);
      end else begin
         chk("ack_latency", 32'(lat), 32'd2);
      end
   endtask

   task automatic wr32(input logic [31:0] ad, input logic [31:0] wd);
      logic [31:0] r;
      logic        e;
      xfer(1'b1, 2'b00, ad, wd, r, e);
      chk("wr_err", {31'd0, e}, 32'd0);
   endtask

   task automatic rd32(input string nm, input logic [31:0] ad,
                       input logic [31:0] exp);
      logic [31:0] r;
      logic        e;
      xfer(1'b0, 2'b00, ad, 32'd0, r, e);
      chk(nm, r, exp);
   endtask

   initial begin
      int  first;
      bit  seen;

      v[0]  = '{"rst_ctrl",   0, 2'b00, B+0,  32'h0,         32'h0,         0};
      v[1]  = '{"rst_preset", 0, 2'b00, B+4,  32'h0,         32'h0,         0};
      v[2]  = '{"wr_preset",  1, 2'b00, B+4,  32'h1122_3344, 32'h0,         0};
      v[3]  = '{"wr_byte5",   1, 2'b10, B+5,  32'h0000_AB00, 32'h0,         0};
      v[4]  = '{"rd_preset",  0, 2'b00, B+4,  32'h0,         32'h1122_AB44, 0};
      v[5]  = '{"rd_half6",   0, 2'b01, B+6,  32'h0,         32'h0000_1122, 0};
      v[6]  = '{"rd_byte5",   0, 2'b10, B+5,  32'h0,         32'h0000_00AB, 0};
      v[7]  = '{"rd_count",   0, 2'b00, B+8,  32'h0,         32'h1122_AB44, 0};
      v[8]  = '{"err_word2",  0, 2'b00, B+2,  32'h0,         32'h0,         1};
      v[9]  = '{"err_half1",  0, 2'b01, B+1,  32'h0,         32'h0,         1};
      v[10] = '{"err_b16",    0, 2'b00, B+16, 32'h0,         32'h0,         1};
      v[11] = '{"err_wr6",    1, 2'b00, B+6,  32'hFFFF_FFFF, 32'h0,         1};
      v[12] = '{"rd_size3",   0, 2'b11, B+4,  32'h0,         32'h1122_AB44, 0};
      v[13] = '{"wr_count",   1, 2'b00, B+8,  32'h0000_0055, 32'h0,         0};
      v[14] = '{"rd_count2",  0, 2'b00, B+8,  32'h0,         32'h1122_AB44, 0};
      v[15] = '{"wr_rsvd",    1, 2'b00, B+12, 32'hFFFF_FFFF, 32'h0,         0};
      v[16] = '{"rd_rsvd",    0, 2'b00, B+12, 32'h0,         32'h0,         0};
      v[17] = '{"wr_half6",   1, 2'b01, B+6,  32'hBEEF_0000, 32'h0,         0};
      v[18] = '{"rd_preset2", 0, 2'b00, B+4,  32'h0,         32'hBEEF_AB44, 0};
      v[19] = '{"err_below",  0, 2'b00, B-4,  32'h0,         32'h0,         1};
      v[20] = '{"rd_byte7",   0, 2'b10, B+7,  32'h0,         32'h0000_00BE, 0};

      bus.Req    = 1'b0;
      bus.We     = 1'b0;
      bus.Size   = 2'b00;
      bus.Ad     = 32'd0;
      bus.WrData = 32'd0;
      Reset      = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_ack",    {31'd0, bus.Ack}, 32'd0);
      chk("rst_err",    {31'd0, bus.Err}, 32'd0);
      chk("rst_irq",    {31'd0, bus.Irq}, 32'd0);
      chk("rst_rddata", bus.RdData,       32'd0);
      Reset = 1'b0;

      foreach (v[i]) begin
         logic [31:0] r;
         logic        e;
         xfer(v[i].we, v[i].size, v[i].ad, v[i].wd, r, e);
         chk({v[i].nm, "_rd"},  r,            v[i].rd);
         chk({v[i].nm, "_err"}, {31'd0, e},   {31'd0, v[i].err});
      end

      // One-shot: enable write lands on edge Ew, expiry at Ew+5.
      wr32(B+4, 32'd5);
      rd32("os_count5", B+8, 32'd5);
      wr32(B+0, 32'h5);
      first = -1;
      for (int k = 0; k <= 10; k++) begin
         @(negedge Clk);
         if (bus.Irq && first < 0) first = k;
      end
      chk("os_irq_delay", 32'(first), 32'd5);
      rd32("os_ctrl", B+0, 32'h8000_0004);
      rd32("os_count0", B+8, 32'd0);
      wr32(B+0, 32'h8000_0000);
      @(negedge Clk);
      chk("os_irq_clr", {31'd0, bus.Irq}, 32'd0);

      // Auto-reload, period 3: reads land at Ew+2, Ew+6, Ew+10.
      wr32(B+4, 32'd3);
      wr32(B+0, 32'h7);
      rd32("ar_cnt_a", B+8, 32'd1);
      chk("ar_irq_a", {31'd0, bus.Irq}, 32'd0);
      @(negedge Clk);
      rd32("ar_cnt_b", B+8, 32'd3);
      chk("ar_irq_b", {31'd0, bus.Irq}, 32'd1);
      @(negedge Clk);
      rd32("ar_cnt_c", B+8, 32'd2);
      chk("ar_irq_c", {31'd0, bus.Irq}, 32'd1);
      wr32(B+0, 32'h8000_0007);
      @(negedge Clk);
      chk("ar_irq_drop", {31'd0, bus.Irq}, 32'd0);
      wr32(B+0, 32'h8000_0000);
      wr32(B+0, 32'h8000_0000);
      rd32("ar_ctrl_off", B+0, 32'h0);

      // Clear of pending written on the very edge the count expires.
      wr32(B+4, 32'd3);
      wr32(B+0, 32'h5);
      wr32(B+0, 32'h8000_0004);
      @(negedge Clk);
      chk("race_irq", {31'd0, bus.Irq}, 32'd1);
      rd32("race_ctrl", B+0, 32'h8000_0004);
      wr32(B+0, 32'h8000_0000);
      @(negedge Clk);
      chk("race_irq_clr", {31'd0, bus.Irq}, 32'd0);

      // Reset while a PRESET write sits in WAIT.
      wr32(B+4, 32'h0000_1234);
      @(negedge Clk);
      bus.Req    = 1'b1;
      bus.We     = 1'b1;
      bus.Size   = 2'b00;
      bus.Ad     = B+4;
      bus.WrData = 32'hDEAD_BEEF;
      @(posedge Clk);
      #1;
      bus.Req = 1'b0;
      Reset   = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         if (bus.Ack) seen = 1;
         if (k == 0) begin
            chk("abort_rddata", bus.RdData,       32'd0);
            chk("abort_err",    {31'd0, bus.Err}, 32'd0);
            chk("abort_irq",    {31'd0, bus.Irq}, 32'd0);
         end
      end
      chk("abort_noack", {31'd0, seen}, 32'd0);
      rd32("abort_preset", B+4, 32'd0);
      rd32("abort_count",  B+8, 32'd0);
      wr32(B+4, 32'h0000_00C0);
      rd32("after_preset", B+4, 32'h0000_00C0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
